// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Four-state instruction fetch/issue sequencer. Reads 8-bit
//                words from an external combinational ROM, resolves JMP and
//                HALT locally, and offers all other instructions to a
//                consumer over a valid/ready handshake.
//
//  Ports
//    clk          in   1  single clock, rising-edge active
//    rst          in   1  synchronous active-high reset
//    start        in   1  begin execution from RESET_PC (IDLE/HALT only)
//    rom_addr     out  4  instruction ROM address (the PC register)
//    rom_data     in   8  instruction word for rom_addr, same cycle
//    issue_valid  out  1  decoded instruction offered
//    issue_ready  in   1  consumer accepts the offered instruction
//    issue_op     out  3  opcode, ir[7:5]
//    issue_imm    out  5  operand, ir[4:0]
//    pc           out  4  address of the current instruction
//    busy         out  1  high in FETCH and ISSUE
//    halted       out  1  high in HALT
//    issue_count  out  8  accepted issues, saturating at 255
//
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic [2:0] issue_op,
    output logic [4:0] issue_imm,
    output logic [3:0] pc,
    output logic       busy,
    output logic       halted,
    output logic [7:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_JMP    = 3'b110;
    localparam logic [2:0] c_OP_HALT   = 3'b111;
    localparam logic [7:0] c_COUNT_MAX = 8'hFF;

    state_t     r_state;
    logic [3:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_count;

    state_t     w_state_nxt;
    logic [3:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic [7:0] w_count_nxt;
    logic       w_issue_valid;
    logic       w_busy;
    logic       w_halted;

    // ------------------------------------------------------------------------
    // State register. Reset wins over every other update, which is what
    // aborts an in-flight handshake without advancing pc or the counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_count <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_count_nxt   = r_count;
        w_issue_valid = 1'b0;
        w_busy        = 1'b0;
        w_halted      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_count_nxt = 8'h00;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                w_busy   = 1'b1;
                w_ir_nxt = rom_data;
                // Branches are resolved here from the raw ROM word so a taken
                // JMP costs one FETCH cycle and never reaches the consumer.
                case (rom_data[7:5])
                    c_OP_JMP:  w_pc_nxt    = rom_data[3:0];
                    c_OP_HALT: w_state_nxt = S_HALT;
                    default:   w_state_nxt = S_ISSUE;
                endcase
            end

            S_ISSUE: begin
                w_busy        = 1'b1;
                w_issue_valid = 1'b1;
                if (issue_ready) begin
                    w_pc_nxt    = r_pc + 4'd1;
                    w_state_nxt = S_FETCH;
                    if (r_count != c_COUNT_MAX) begin
                        w_count_nxt = r_count + 8'd1;
                    end
                end
            end

            S_HALT: begin
                w_halted = 1'b1;
                if (start) begin
                    w_pc_nxt    = RESET_PC;
                    w_count_nxt = 8'h00;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. The issue fields come straight from ir, which only changes in
    // FETCH, so they hold steady for the whole ISSUE stall.
    // ------------------------------------------------------------------------
    assign rom_addr    = r_pc;
    assign pc          = r_pc;
    assign issue_op    = r_ir[7:5];
    assign issue_imm   = r_ir[4:0];
    assign issue_valid = w_issue_valid;
    assign busy        = w_busy;
    assign halted      = w_halted;
    assign issue_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer. A small
//                ROM array feeds the DUT; expected issues are queued before
//                each program runs and compared as handshakes occur.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_op;
    logic [4:0] issue_imm;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic [7:0] issue_count;

    logic [7:0] rom [16];

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  imm;
        logic [3:0]  pc;
        logic [31:0] cyc;
    } exp_t;

    exp_t sbq[$];

    int   total;
    int   bad;
    logic saw_halt;

    fetch_sequencer #(.RESET_PC(4'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_imm   (issue_imm),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rom_data = rom[rom_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [4:0] imm,
                        input logic [3:0] p, input logic [31:0] cyc);
        exp_t e;
        e.op  = op;
        e.imm = imm;
        e.pc  = p;
        e.cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic fill_rom(input logic [7:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Called in cycle 1 after start; cycle numbers in the queue use that base.
    task automatic run_issues(input int maxcyc);
        exp_t e;
        int   c;
        c = 1;
        while (sbq.size() > 0 && c <= maxcyc) begin
            if (issue_valid && issue_ready) begin
                e = sbq.pop_front();
                chk("issue_op", 32'(issue_op), 32'(e.op));
                chk("issue_imm", 32'(issue_imm), 32'(e.imm));
                chk("issue_pc", 32'(pc), 32'(e.pc));
                if (e.cyc != 0) chk("issue_cycle", c, e.cyc);
            end
            if (halted) saw_halt = 1'b1;
            tick;
            c++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        saw_halt    = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        issue_ready = 1'b0;
        fill_rom(8'h00);

        // ---------------- reset state ----------------
        tick;
        tick;
        chk("rst_valid", 32'(issue_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_op", 32'(issue_op), 0);
        chk("rst_imm", 32'(issue_imm), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_romaddr", 32'(rom_addr), 0);
        chk("rst_count", 32'(issue_count), 0);

        // ---------------- baseline program with JMP loop ----------------
        fill_rom(8'h00);
        rom[0] = 8'h60; rom[1] = 8'h80; rom[2] = 8'hA0; rom[3] = 8'hC1; rom[4] = 8'hFF;
        do_reset;
        issue_ready = 1'b1;
        saw_halt    = 1'b0;
        pulse_start;
        push(3'd3, 5'd0, 4'd0, 2);
        push(3'd4, 5'd0, 4'd1, 4);
        push(3'd5, 5'd0, 4'd2, 6);
        push(3'd4, 5'd0, 4'd1, 9);
        push(3'd5, 5'd0, 4'd2, 11);
        push(3'd4, 5'd0, 4'd1, 14);
        push(3'd5, 5'd0, 4'd2, 16);
        run_issues(40);
        chk("base_no_halt", 32'(saw_halt), 0);

        // ---------------- single issue then HALT ----------------
        fill_rom(8'h00);
        rom[0] = 8'h25; rom[1] = 8'hE0;
        do_reset;
        issue_ready = 1'b1;
        pulse_start;
        push(3'd1, 5'd5, 4'd0, 2);
        run_issues(20);
        tick;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 1);
        chk("halt_count", 32'(issue_count), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_valid", 32'(issue_valid), 0);
        tick;
        chk("halt_stays", 32'(halted), 1);

        // ---------------- restart from HALT ----------------
        pulse_start;
        chk("restart_pc", 32'(pc), 0);
        chk("restart_count", 32'(issue_count), 0);
        chk("restart_busy", 32'(busy), 1);
        push(3'd1, 5'd5, 4'd0, 2);
        run_issues(20);
        tick;
        chk("restart_halted", 32'(halted), 1);
        chk("restart_count_end", 32'(issue_count), 1);

        // ---------------- backpressure ----------------
        fill_rom(8'h00);
        rom[0] = 8'h4A; rom[1] = 8'hE0;
        do_reset;
        issue_ready = 1'b0;
        pulse_start;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(issue_valid), 1);
            chk("bp_op", 32'(issue_op), 2);
            chk("bp_imm", 32'(issue_imm), 10);
            chk("bp_pc", 32'(pc), 0);
            tick;
        end
        issue_ready = 1'b1;
        chk("bp_pc_before", 32'(pc), 0);
        tick;
        chk("bp_pc_after", 32'(pc), 1);
        chk("bp_valid_after", 32'(issue_valid), 0);
        chk("bp_count", 32'(issue_count), 1);
        tick;
        chk("bp_halted", 32'(halted), 1);

        // ---------------- pc wrap and count saturation ----------------
        fill_rom(8'h20);
        do_reset;
        issue_ready = 1'b1;
        saw_halt    = 1'b0;
        pulse_start;
        for (int i = 0; i < 16; i++) push(3'd1, 5'd0, 4'(i), 0);
        push(3'd1, 5'd0, 4'd0, 0);
        run_issues(60);
        for (int i = 0; i < 600; i++) begin
            if (halted) saw_halt = 1'b1;
            tick;
        end
        chk("wrap_count_sat", 32'(issue_count), 255);
        tick;
        tick;
        chk("wrap_count_hold", 32'(issue_count), 255);
        chk("wrap_no_halt", 32'(saw_halt), 0);

        // ---------------- reset during handshake ----------------
        fill_rom(8'h20);
        do_reset;
        issue_ready = 1'b1;
        pulse_start;
        tick;
        chk("abort_valid_pre", 32'(issue_valid), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_valid", 32'(issue_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pc", 32'(pc), 0);
        chk("abort_count", 32'(issue_count), 0);
        rst   = 1'b1;
        start = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_over_start", 32'(busy), 0);

        // ---------------- JMP to self ----------------
        fill_rom(8'h00);
        rom[0] = 8'hC3; rom[3] = 8'hC3;
        do_reset;
        issue_ready = 1'b1;
        pulse_start;
        tick;
        tick;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("self_busy", 32'(busy), 1);
            chk("self_pc", 32'(pc), 3);
            chk("self_valid", 32'(issue_valid), 0);
            tick;
        end
        start = 1'b0;
        chk("self_count", 32'(issue_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
